// File: rtl/div_share_arbiter_pkg.sv
// div_arb_pkg: shared types and helpers for the shared-divider arbiter.
//   DIV_DW        operand/result width of the divider core
//   DIV_LATENCY   default divider pipeline depth (ce-gated cycles)
//   tag_t         per-stage tag that travels alongside an op in the divider
//   rr_pick       round-robin one-hot pick starting at a pointer
//   onehot_idx    encoder for a one-hot vector
package div_arb_pkg;

  localparam int DIV_DW      = 32;
  localparam int DIV_LATENCY = 36;
  localparam int MAX_NREQ    = 8;
  localparam int ID_W        = 3;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic            dz;
  } tag_t;

  // First set bit of req at or after ptr, wrapping within the low n bits.
  function automatic logic [MAX_NREQ-1:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                                  input logic [ID_W-1:0]     ptr,
                                                  input int                  n);
    logic [MAX_NREQ-1:0] gnt;
    logic                found;
    logic [ID_W-1:0]     sel;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      sel = ID_W'((int'(ptr) + i) % n);
      if ((i < n) && !found && req[sel]) begin
        gnt[sel] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

  // Valid only for one-hot or all-zero input (all-zero yields 0).
  function automatic logic [ID_W-1:0] onehot_idx(input logic [MAX_NREQ-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (v[i]) idx = idx | ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/div_share_arbiter_rr_arbiter.sv
// rr_arbiter: NREQ-wide round-robin arbiter with an internal rotating pointer.
//   clk, rst_n  clock, asynchronous active-low reset
//   req         request vector
//   en          arbitration enable; gnt is all-zero when low
//   gnt         one-hot grant (combinational from req/en/ptr)
// Every grant is taken by its requester in the same cycle, so the pointer
// advances to winner+1 whenever gnt is non-zero.
module rr_arbiter
  import div_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt
);

  logic [PW-1:0]       ptr;
  logic [PW-1:0]       ptr_nxt;
  logic [MAX_NREQ-1:0] pick;
  logic [ID_W-1:0]     win;

  always_comb begin
    pick    = rr_pick(MAX_NREQ'(req), ID_W'(ptr), NREQ);
    gnt     = en ? pick[NREQ-1:0] : '0;
    win     = onehot_idx(pick);
    ptr_nxt = PW'((int'(win) + 1) % NREQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: shares one pipelined divider among NREQ requesters.
//   req_valid/req_ready/req_dividend/req_divisor   per-requester operand ports
//   rsp_valid/rsp_ready                             per-requester result handshake
//   rsp_quotient/rsp_fractional/rsp_divzero         result of the op at the tag head
//   div_ce/div_dividend/div_divisor                 to the divider core
//   div_quotient/div_fractional                     from the divider core
//   inflight                                        ops issued and not yet handed off
// Handshake: a transfer happens on a clock edge where valid & ready are both
// high; req_ready is a one-hot grant and may depend on req_valid; once valid
// is raised, the payload is held until that transfer.
// A tag pipeline of LATENCY stages shifts in lock-step with the divider
// (both gated by div_ce), so the tag head always describes the divider output.
module div_share_arbiter
  import div_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int LATENCY  = DIV_LATENCY,
  parameter int DW       = DIV_DW,
  localparam int IFW     = $clog2(LATENCY + 2)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_dividend,
  input  logic [NREQ*DW-1:0] req_divisor,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [DW-1:0]      rsp_quotient,
  output logic [DW-1:0]      rsp_fractional,
  output logic               rsp_divzero,
  output logic               div_ce,
  output logic [DW-1:0]      div_dividend,
  output logic [DW-1:0]      div_divisor,
  input  logic [DW-1:0]      div_quotient,
  input  logic [DW-1:0]      div_fractional,
  output logic [IFW-1:0]     inflight
);

  tag_t            pipe [LATENCY];
  tag_t            head;
  logic            stall;
  logic            arb_en;
  logic [NREQ-1:0] gnt;
  logic            issue;
  logic            handoff;
  logic [ID_W-1:0] win_id;
  logic            op_dz;

  assign head = pipe[LATENCY-1];

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (head.vld && (head.id == ID_W'(i))) rsp_valid[i] = 1'b1;
    end
  end

  assign rsp_quotient   = div_quotient;
  assign rsp_fractional = div_fractional;
  assign rsp_divzero    = head.vld & head.dz;

  // A held result freezes the whole divider so its output stays on rsp_*.
  assign stall   = |(rsp_valid & ~rsp_ready);
  assign div_ce  = ~stall;
  assign handoff = |(rsp_valid & rsp_ready);

  // No grant while reset is asserted so req_ready reads zero immediately.
  assign arb_en = ~stall & rst_n;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .en    (arb_en),
    .gnt   (gnt)
  );

  assign req_ready = gnt;
  assign issue     = |gnt;
  assign win_id    = onehot_idx(MAX_NREQ'(gnt));

  always_comb begin
    div_dividend = '0;
    div_divisor  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        div_dividend = req_dividend[i*DW +: DW];
        div_divisor  = req_divisor[i*DW +: DW];
      end
    end
  end

  assign op_dz = (div_divisor == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LATENCY; k++) pipe[k] <= '0;
    end else if (div_ce) begin
      pipe[0] <= '{vld: issue, id: win_id, dz: issue & op_dz};
      for (int k = 1; k < LATENCY; k++) pipe[k] <= pipe[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({issue, handoff})
        2'b10:   inflight <= inflight + IFW'(1);
        2'b01:   inflight <= inflight - IFW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_arbiter.sv
module tb_div_share_arbiter;
  localparam int NREQ  = 4;
  localparam int LAT   = 36;
  localparam int DW    = 32;
  localparam int IFW   = $clog2(LAT + 2);
  localparam int EXP_W = 2 + 1 + 2 * DW;

  typedef struct packed {
    logic [DW-1:0] dvd;
    logic [DW-1:0] dvs;
    logic [DW-1:0] q;
    logic [DW-1:0] f;
    logic          dz;
  } op_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_dividend;
  logic [NREQ*DW-1:0] req_divisor;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [DW-1:0]      rsp_quotient;
  logic [DW-1:0]      rsp_fractional;
  logic               rsp_divzero;
  logic               div_ce;
  logic [DW-1:0]      div_dividend;
  logic [DW-1:0]      div_divisor;
  logic [DW-1:0]      div_quotient;
  logic [DW-1:0]      div_fractional;
  logic [IFW-1:0]     inflight;

  div_share_arbiter #(.NREQ(NREQ), .LATENCY(LAT), .DW(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dividend   (req_dividend),
    .req_divisor    (req_divisor),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_quotient   (rsp_quotient),
    .rsp_fractional (rsp_fractional),
    .rsp_divzero    (rsp_divzero),
    .div_ce         (div_ce),
    .div_dividend   (div_dividend),
    .div_divisor    (div_divisor),
    .div_quotient   (div_quotient),
    .div_fractional (div_fractional),
    .inflight       (inflight)
  );

  // ---------------- behavioural divider: LAT stages gated by ce ----------------
  logic [DW-1:0] mq [LAT];
  logic [DW-1:0] mf [LAT];
  initial for (int k = 0; k < LAT; k++) begin mq[k] = '0; mf[k] = '0; end
  always @(posedge clk) begin
    if (div_ce) begin
      mq[0] <= (div_divisor == '0) ? '0 : div_dividend / div_divisor;
      mf[0] <= (div_divisor == '0) ? '0 : div_dividend % div_divisor;
      for (int k = 1; k < LAT; k++) begin
        mq[k] <= mq[k-1];
        mf[k] <= mf[k-1];
      end
    end
  end
  assign div_quotient   = mq[LAT-1];
  assign div_fractional = mf[LAT-1];

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  op_t              pend_q[NREQ][$];
  op_t              cur[NREQ];
  int               gnt_log[$];
  int               errors = 0;
  int               checks = 0;
  logic             rst_req = 1'b1;
  logic             rand_rdy = 1'b0;
  logic [NREQ-1:0]  rdy_mask = '1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic add_op(input int id, input logic [DW-1:0] dvd, input logic [DW-1:0] dvs,
                        input logic [DW-1:0] q, input logic [DW-1:0] f, input logic dz);
    op_t o;
    o.dvd = dvd; o.dvs = dvs; o.q = q; o.f = f; o.dz = dz;
    pend_q[id].push_back(o);
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NREQ; i++) s += pend_q[i].size();
    return s;
  endfunction

  // ---------------- driver: owns rst_n, req_*, rsp_ready ----------------
  initial begin : driver
    logic [NREQ-1:0] acc;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    rsp_ready    = '1;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          exp_q.push_back({2'(i), cur[i].dz, cur[i].q, cur[i].f});
          gnt_log.push_back(i);
        end
      end
      @(posedge clk);
      #1;
      rst_n     = ~rst_req;
      rsp_ready = rand_rdy ? NREQ'($urandom_range(0, 15)) : rdy_mask;
      if (rst_req) begin
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) pend_q[i].delete();
        exp_q.delete();
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (acc[i] || !req_valid[i]) begin
            if (pend_q[i].size() > 0) begin
              cur[i] = pend_q[i].pop_front();
              req_valid[i] = 1'b1;
              req_dividend[i*DW +: DW] = cur[i].dvd;
              req_divisor[i*DW +: DW]  = cur[i].dvs;
            end else begin
              req_valid[i] = 1'b0;
            end
          end
        end
      end
    end
  end

  // ---------------- monitor: pops on every response hand-off ----------------
  initial begin : monitor
    logic [EXP_W-1:0] e;
    int id;
    forever begin
      @(negedge clk);
      if (rst_n && |(rsp_valid & rsp_ready)) begin
        chk("rsp_onehot", 64'($countones(rsp_valid)), 1);
        id = 0;
        for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) id = i;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: rsp_valid=%b with nothing outstanding", rsp_valid);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", 64'(id), 64'(e[EXP_W-1 -: 2]));
          chk("rsp_dz", 64'(rsp_divzero), 64'(e[2*DW]));
          if (!e[2*DW]) begin
            chk("rsp_quotient", 64'(rsp_quotient), 64'(e[2*DW-1 -: DW]));
            chk("rsp_fractional", 64'(rsp_fractional), 64'(e[DW-1:0]));
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_req = 1'b1;
    @(posedge clk);
    #2;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst_req = 1'b0;
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || pending() != 0 || req_valid != 0 || inflight != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain_in_time"}, 64'(n < 500), 1);
    chk({name, "_inflight_zero"}, 64'(inflight), 0);
  endtask

  initial begin : main
    int n;
    int stale;
    logic [DW-1:0]  sq, sf;
    logic [IFW-1:0] si;

    // reset state
    @(posedge clk);
    #2;
    chk("reset_rsp_valid", 64'(rsp_valid), 0);
    chk("reset_req_ready", 64'(req_ready), 0);
    chk("reset_inflight", 64'(inflight), 0);
    chk("reset_div_ce", 64'(div_ce), 1);
    do_reset(2);

    // 1: single op, latency and value
    @(negedge clk);
    add_op(0, 100, 7, 14, 2, 0);
    n = 0;
    while (!(req_valid[0] && req_ready[0]) && n < 50) begin @(negedge clk); n++; end
    chk("t1_accept_in_time", 64'(n < 50), 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid[0] && n < 200);
    chk("t1_latency", 64'(n), 64'(LAT));
    drain("t1");

    // 2: four requesters streaming, round-robin, one result per clock
    do_reset(2);
    gnt_log.delete();
    @(negedge clk);
    add_op(0, 1000, 10, 100, 0, 0);   add_op(0, 1001, 10, 100, 1, 0);   add_op(0, 50, 7, 7, 1, 0);
    add_op(1, 81, 9, 9, 0, 0);        add_op(1, 82, 9, 9, 1, 0);        add_op(1, 17, 5, 3, 2, 0);
    add_op(2, 200, 3, 66, 2, 0);      add_op(2, 7, 8, 0, 7, 0);         add_op(2, 1, 1, 1, 0, 0);
    add_op(3, 65535, 256, 255, 255, 0); add_op(3, 123456, 1000, 123, 456, 0); add_op(3, 0, 5, 0, 0, 0);
    n = 0;
    while (rsp_valid == 0 && n < 200) begin @(negedge clk); n++; end
    for (int k = 0; k < 12; k++) begin
      chk("t2_throughput", 64'(|(rsp_valid & rsp_ready)), 1);
      @(negedge clk);
    end
    drain("t2");
    chk("t2_grant_count", 64'(gnt_log.size()), 12);
    for (int k = 0; k < 12 && k < gnt_log.size(); k++) chk("t2_grant_order", 64'(gnt_log[k]), 64'(k % 4));

    // 3: backpressure on requester 2 freezes the divider
    @(negedge clk);
    rdy_mask = 4'b1011;
    add_op(0, 12, 4, 3, 0, 0); add_op(1, 13, 4, 3, 1, 0);
    add_op(2, 14, 4, 3, 2, 0); add_op(3, 15, 4, 3, 3, 0);
    add_op(2, 100, 9, 11, 1, 0);
    n = 0;
    while (!rsp_valid[2] && n < 200) begin @(negedge clk); n++; end
    chk("t3_head2_in_time", 64'(n < 200), 1);
    add_op(3, 20, 6, 3, 2, 0);
    sq = rsp_quotient; sf = rsp_fractional; si = inflight;
    chk("t3_inflight_at_stall", 64'(si), 3);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("t3_div_ce", 64'(div_ce), 0);
      chk("t3_req_ready", 64'(req_ready), 0);
      chk("t3_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
      chk("t3_quot_stable", 64'(rsp_quotient), 64'(sq));
      chk("t3_frac_stable", 64'(rsp_fractional), 64'(sf));
      chk("t3_inflight_stable", 64'(inflight), 64'(si));
      @(negedge clk);
    end
    chk("t3_req3_waiting", 64'(req_valid[3]), 1);
    rdy_mask = 4'hf;
    drain("t3");

    // 4: divide by zero passes through flagged, next op unaffected
    @(negedge clk);
    add_op(1, 5, 0, 0, 0, 1);
    add_op(1, 9, 3, 3, 0, 0);
    drain("t4");

    // 5: reset with ops in flight
    @(negedge clk);
    for (int k = 0; k < 10; k++) add_op(k % 4, 1, 1, 1, 0, 0);
    repeat (14) @(negedge clk);
    chk("t5_inflight10", 64'(inflight), 10);
    rst_req = 1'b1;
    @(posedge clk);
    #2;
    chk("t5_rst_rsp_valid", 64'(rsp_valid), 0);
    chk("t5_rst_req_ready", 64'(req_ready), 0);
    chk("t5_rst_inflight", 64'(inflight), 0);
    chk("t5_rst_div_ce", 64'(div_ce), 1);
    chk("t5_rst_div_dividend", 64'(div_dividend), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_req = 1'b0;
    stale = 0;
    for (int k = 0; k < 2 * LAT; k++) begin
      @(negedge clk);
      if (rsp_valid != 0) stale++;
    end
    chk("t5_no_stale_rsp", 64'(stale), 0);
    add_op(2, 77, 7, 11, 0, 0);
    drain("t5");

    // 6: sparse traffic with random response backpressure
    rand_rdy = 1'b1;
    @(negedge clk);
    add_op(0, 1000000, 3, 333333, 1, 0);
    repeat ($urandom_range(0, 6)) @(negedge clk);
    add_op(1, 32'hFFFF_FFFF, 65536, 65535, 65535, 0);
    repeat ($urandom_range(0, 6)) @(negedge clk);
    add_op(2, 10, 20, 0, 10, 0);
    repeat ($urandom_range(0, 6)) @(negedge clk);
    add_op(3, 999, 999, 1, 0, 0);
    repeat ($urandom_range(0, 6)) @(negedge clk);
    add_op(0, 77, 8, 9, 5, 0);
    repeat ($urandom_range(0, 6)) @(negedge clk);
    add_op(2, 3, 0, 0, 0, 1);
    repeat ($urandom_range(0, 6)) @(negedge clk);
    add_op(1, 1024, 32, 32, 0, 0);
    repeat ($urandom_range(0, 6)) @(negedge clk);
    add_op(3, 32'h8000_0000, 7, 306783378, 2, 0);
    repeat (60) @(negedge clk);
    rand_rdy = 1'b0;
    drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
